nmi_arbiter: RTL
================

# nmi_arbiter

Arbitrates the three NMI sources (magic button, DivMMC button, pause button) onto the single Z80 /NMI line. Each source is debounced, latched as pending, and granted by fixed priority on a frame boundary. /NMI is held until the CPU fetches 0x0066, and the grant stays locked until magic-ROM code acknowledges it through a status port. Sits between the front-panel inputs and the magic-mode controller, replacing direct button-to-NMI wiring.

## Interface

Parameters:
- DEBOUNCE_W, 16: debounce counter width; an input must be stable for 2^DEBOUNCE_W-1 clk28 cycles to be accepted.
- TIMEOUT_FRAMES, 4: frame edges allowed in ASSERT before the request is dropped.

Ports:
- clk28  in  1  system clock, 28 MHz.
- rst_n  in  1  asynchronous reset, active-low.
- bus  cpu_bus  -  reads mreq, m1, rd, wr, ioreq, a[15:0], d[7:0].
- n_int, n_int_next  in  1 each  frame-interrupt current/next level; frame edge = n_int==1 && n_int_next==0.
- magic_map  in  1  magic ROM mapped; gates status-port access.
- magic_button, div_button, pause_button  in  1 each  raw asynchronous buttons, active-high.
- n_nmi  out  1  Z80 /NMI, active-low, registered.
- nmi_cause  out  2  current grant: 0 none, 1 magic, 2 div, 3 pause.
- d_out  out  8  status-read data.
- d_out_active  out  1  drive d_out onto the CPU bus.

## Operation

- Each button passes through a 2-FF synchronizer, then a `button_debounce` instance. A rising debounced edge sets that source's pending bit. A pending bit that is already set stays set; presses do not count.
- FSM states are IDLE, ASSERT and SERVICE.
- IDLE: when any pending bit is set and a frame edge occurs, grant the highest-priority source (magic > div > pause). Set nmi_cause, drive n_nmi=0, go to ASSERT.
- ASSERT: on bus.m1 && bus.mreq && a==16'h0066, drive n_nmi=1, clear the granted pending bit, go to SERVICE.
- SERVICE: n_nmi=1. Exit to IDLE only on an ack write, which also sets nmi_cause=0.
- Status port 16'h0DFF, decoded as magic_map && ioreq && a[7:0]==FF && a[15:8]==0D.
  - Read data: {1'b0, pending[2:0] (pause,div,magic), 1'b0, timeout_flag, nmi_cause}.
  - Write: d[0]=1 acknowledges (SERVICE→IDLE, ignored in other states); d[2]=1 clears timeout_flag.
- Simultaneous events:
  - A press of the granted source during ASSERT is absorbed: the pending bit is still cleared on fetch.
  - A press of the granted source during SERVICE re-sets its pending bit, and it is serviced after ack.
  - Ack and a frame edge in the same cycle: go to IDLE; the new grant happens at the next frame edge.
- Reset values: n_nmi=1, nmi_cause=0, pending=0, timeout_flag=0, d_out_active=0, state IDLE, debounce counters 0, debounced levels 0.
- Reset mid-operation immediately releases /NMI and discards all pending requests.

## Timing

- Debounce latency: 2 sync cycles + 2^DEBOUNCE_W-1 stable cycles. Any input change restarts the counter.
- Pending bit sets 1 cycle after the debounced level rises.
- n_nmi falls 1 cycle after the frame-edge cycle, and rises 1 cycle after the 0x0066 fetch cycle.
- d_out_active is registered: high the cycle after a decoded read, for as long as the read persists. d_out is combinational from status.
- Ack write takes effect 1 cycle after the cycle in which wr is sampled.

## Configuration

- NMI_ARBITER_TIMEOUT_EN defined:
  - A 3-bit frame-edge counter runs in ASSERT.
  - On the TIMEOUT_FRAMES-th edge: n_nmi=1, granted pending bit cleared, timeout_flag=1, nmi_cause=0, state IDLE.
  - The counter clears whenever ASSERT is entered.
- Macro undefined: ASSERT holds indefinitely; timeout_flag always reads 0.

## Structure

- In package common: nmi_src_t enum (NMI_NONE, NMI_MAGIC, NMI_DIV, NMI_PAUSE), the constant NMI_STATUS_PORT = 16'h0DFF, and the status bit-position constants.
- Sub-module `button_debounce` (parameter W; ports clk28, rst_n, in, out) holds the synchronizer and counter. It is instantiated three times.

## Test plan

- Magic press held 2^DEBOUNCE_W cycles, then frame edge → n_nmi low next cycle, nmi_cause=1; fetch at 0x0066 → n_nmi high next cycle, status read returns 8'h01.
- Pause and magic debounced in the same cycle → magic granted first. After ack 8'h01, pause is granted at the next frame edge, cause=3.
- Button glitch shorter than 2^DEBOUNCE_W-1 cycles → no pending bit, n_nmi stays 1 across 3 frames.
- With NMI_ARBITER_TIMEOUT_EN: div granted, no 0x0066 fetch for 4 frame edges → n_nmi=1, status reads 8'h04. Write 8'h04 → status reads 8'h00.
- Status read with magic_map=0 → d_out_active stays 0. Ack write with magic_map=0 → SERVICE retained.
- rst_n asserted during ASSERT → n_nmi=1 immediately, all status bits 0 after release.

Source files
------------

// File: rtl/nmi_arbiter_pkg.sv
// Shared types and constants for the NMI arbiter: grant sources, FSM states,
// status-port address and status-byte bit positions.
package nmi_arbiter_pkg;

  typedef enum logic [1:0] {
    NMI_NONE  = 2'd0,
    NMI_MAGIC = 2'd1,
    NMI_DIV   = 2'd2,
    NMI_PAUSE = 2'd3
  } nmi_src_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } arb_state_t;

  localparam logic [15:0] NMI_STATUS_PORT = 16'h0DFF;
  localparam logic [15:0] NMI_VECTOR      = 16'h0066;

  // Status byte layout: {0, pending[2:0], 0, timeout_flag, nmi_cause[1:0]}
  localparam int ST_CAUSE_LSB   = 0;
  localparam int ST_CAUSE_MSB   = 1;
  localparam int ST_TIMEOUT_BIT = 2;
  localparam int ST_PEND_LSB    = 4;
  localparam int ST_PEND_MSB    = 6;

  localparam int WR_ACK_BIT    = 0;
  localparam int WR_TO_CLR_BIT = 2;

  // pending bit 0 = magic, 1 = div, 2 = pause; lowest index wins
  function automatic nmi_src_t pick_source(input logic [2:0] pend);
    if (pend[0])      return NMI_MAGIC;
    else if (pend[1]) return NMI_DIV;
    else if (pend[2]) return NMI_PAUSE;
    else              return NMI_NONE;
  endfunction

  function automatic logic [2:0] src_mask(input nmi_src_t src);
    case (src)
      NMI_MAGIC: return 3'b001;
      NMI_DIV:   return 3'b010;
      NMI_PAUSE: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/nmi_arbiter_if.sv
// Z80 bus view used by the NMI arbiter: fetch/IO strobes, address and write data.
interface nmi_arbiter_if;
  logic        mreq;
  logic        m1;
  logic        rd;
  logic        wr;
  logic        ioreq;
  logic [15:0] a;
  logic [7:0]  d;

  modport master (output mreq, m1, rd, wr, ioreq, a, d);
  modport slave  (input  mreq, m1, rd, wr, ioreq, a, d);
endinterface

// File: rtl/nmi_arbiter_button_debounce.sv
// Two-flop synchronizer plus stability counter; out follows in once the
// synchronized level has differed from out for 2^W-1 consecutive cycles.
module button_debounce #(
  parameter int W = 16
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  // cnt counts differing cycles already seen; the 2^W-1th one flips out
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  logic         sync1;
  logic         sync2;
  logic [W-1:0] cnt;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      out   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      if (sync2 == out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        out <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Debounces magic/div/pause buttons and arbitrates them onto Z80 /NMI.
// Optional ASSERT timeout enabled by defining NMI_ARBITER_TIMEOUT_EN.
//   state      | meaning
//   ST_IDLE    | /NMI released, waiting for a pending source and a frame edge
//   ST_ASSERT  | /NMI low, waiting for the CPU to fetch 0x0066
//   ST_SERVICE | /NMI released, grant locked until the status-port ack write
module nmi_arbiter
  import nmi_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_W     = 16,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic         clk28,
  input  logic         rst_n,
  nmi_arbiter_if.slave bus,
  input  logic         n_int,
  input  logic         n_int_next,
  input  logic         magic_map,
  input  logic         magic_button,
  input  logic         div_button,
  input  logic         pause_button,
  output logic         n_nmi,
  output logic [1:0]   nmi_cause,
  output logic [7:0]   d_out,
  output logic         d_out_active
);

  arb_state_t state, state_nx;
  nmi_src_t   cause_q, cause_nx;
  logic       n_nmi_nx;
  logic [2:0] btn_raw, deb, deb_q, rise;
  logic [2:0] pending, pending_nx, clr_mask;
  logic       timeout_flag, tflag_nx;
  logic       frame_edge, port_sel, rd_sel, wr_sel, ack, to_clr, fetch, to_hit;

  assign btn_raw = {pause_button, div_button, magic_button};

  for (genvar gi = 0; gi < 3; gi++) begin : g_deb
    button_debounce #(.W(DEBOUNCE_W)) u_deb (
      .clk28 (clk28),
      .rst_n (rst_n),
      .in    (btn_raw[gi]),
      .out   (deb[gi])
    );
  end

  assign rise       = deb & ~deb_q;
  assign frame_edge = n_int & ~n_int_next;
  assign port_sel   = magic_map & bus.ioreq & (bus.a == NMI_STATUS_PORT);
  assign rd_sel     = port_sel & bus.rd;
  assign wr_sel     = port_sel & bus.wr;
  assign ack        = wr_sel & bus.d[WR_ACK_BIT];
  assign to_clr     = wr_sel & bus.d[WR_TO_CLR_BIT];
  assign fetch      = bus.m1 & bus.mreq & (bus.a == NMI_VECTOR);

  logic unused_bus;
  assign unused_bus = ^{bus.d[7:3], bus.d[1]};

`ifdef NMI_ARBITER_TIMEOUT_EN
  localparam logic [2:0] TO_LAST = 3'(TIMEOUT_FRAMES - 1);
  logic [2:0] frame_cnt;

  // held at zero outside ASSERT, so every entry starts a fresh count
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)                      frame_cnt <= '0;
    else if (state != ST_ASSERT)     frame_cnt <= '0;
    else if (frame_edge && !fetch)   frame_cnt <= frame_cnt + 3'd1;
  end

  assign to_hit = (state == ST_ASSERT) && frame_edge && (frame_cnt == TO_LAST);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_FRAMES);
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    n_nmi_nx = n_nmi;
    clr_mask = '0;
    case (state)
      ST_IDLE: begin
        if (frame_edge && (|pending)) begin
          cause_nx = pick_source(pending);
          n_nmi_nx = 1'b0;
          state_nx = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (fetch) begin
          n_nmi_nx = 1'b1;
          clr_mask = src_mask(cause_q);
          state_nx = ST_SERVICE;
        end else if (to_hit) begin
          n_nmi_nx = 1'b1;
          clr_mask = src_mask(cause_q);
          cause_nx = NMI_NONE;
          state_nx = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        n_nmi_nx = 1'b1;
        if (ack) begin
          cause_nx = NMI_NONE;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        n_nmi_nx = 1'b1;
        cause_nx = NMI_NONE;
        state_nx = ST_IDLE;
      end
    endcase

    // a fetch in the same cycle as a fresh press still retires the request
    pending_nx = (pending | rise) & ~clr_mask;
    tflag_nx   = to_hit ? 1'b1 : (to_clr ? 1'b0 : timeout_flag);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cause_q      <= NMI_NONE;
      n_nmi        <= 1'b1;
      pending      <= '0;
      deb_q        <= '0;
      timeout_flag <= 1'b0;
      d_out_active <= 1'b0;
    end else begin
      state        <= state_nx;
      cause_q      <= cause_nx;
      n_nmi        <= n_nmi_nx;
      pending      <= pending_nx;
      deb_q        <= deb;
      timeout_flag <= tflag_nx;
      d_out_active <= rd_sel;
    end
  end

  assign nmi_cause = cause_q;

  always_comb begin
    d_out = '0;
    d_out[ST_CAUSE_MSB:ST_CAUSE_LSB] = cause_q;
    d_out[ST_TIMEOUT_BIT]            = timeout_flag;
    d_out[ST_PEND_MSB:ST_PEND_LSB]   = pending;
  end

endmodule
